axis_orb_match_collector: RTL

- Downstream sink for the 32-bit AXI-Stream result words produced by the ORB accelerator stage.
- Splits out the matched keypoint pairs, which arrive in payload bits [19:0] as {x,y} 10+10 values (first point, then second point, each repeated over several beats), plus the per-frame cycle count carried in the last two beats of the frame.
- Deduplicates the repeated payloads, pairs the points into 40-bit match records, and buffers the records in a show-ahead FIFO for the PS-side reader.
- Keeps frame, orphan and overflow statistics.

---
 rtl/axis_orb_match_collector_if.sv | 23 ++
 rtl/axis_orb_match_collector.sv | 136 +++++++++++++
 2 files changed

// File: rtl/axis_orb_match_collector_if.sv
// axis_orb_match_collector_if: result-stream input and match-record output bundle; FRAME_TAG_EN widens records to 48 bits
interface axis_orb_match_collector_if;
`ifdef FRAME_TAG_EN
    localparam int MW = 48;
`else
    localparam int MW = 40;
`endif
    logic [31:0]   s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic [MW-1:0] m_match_data;
    logic          m_match_valid;
    logic          m_match_ready;
    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_match_ready,
        output s_axis_tready, m_match_data, m_match_valid
    );
    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_match_ready,
        input  s_axis_tready, m_match_data, m_match_valid
    );
endinterface

// File: rtl/axis_orb_match_collector.sv
// axis_orb_match_collector: pairs deduplicated ORB keypoints into match records with frame statistics; FRAME_TAG_EN adds an 8-bit frame tag
module axis_orb_match_collector #(
    parameter int H_ACTIVE = 720,
    parameter int V_ACTIVE = 480,
    parameter int DEPTH    = 16
) (
    input  logic                       s_axis_aclk,
    input  logic                       s_axis_areset,
    axis_orb_match_collector_if.slave  bus,
    output logic [$clog2(DEPTH):0]     match_level,
    output logic [19:0]                frame_cycles,
    output logic [15:0]                frame_cnt,
    output logic                       frame_done,
    output logic                       frame_err,
    output logic [15:0]                orphan_cnt,
    output logic [15:0]                overflow_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(H_ACTIVE);
    localparam int RW = $clog2(V_ACTIVE);
`ifdef FRAME_TAG_EN
    localparam int MW = 48;
`else
    localparam int MW = 40;
`endif
    typedef enum logic [1:0] {SYNC, IDLE, HAVE_P1} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [19:0]   prev_q, prev_d, p1_q, p1_d, frame_cycles_q, frame_cycles_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d, orphan_q, orphan_d, overflow_q, overflow_d;
    logic          tready_q, tready_d, frame_done_q, frame_done_d, frame_err_q, frame_err_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0] level_q, level_d;
    logic [MW-1:0] mem_q [DEPTH];
    logic [MW-1:0] rec;
    logic [19:0]   pl;
    logic          acc, tlast_acc, last_col, last_row, stats, chg, push, pop, full, wr_en, orphan_inc;
    logic          unused_tdata;
    // Beat decode, pairing FSM, FIFO bookkeeping and statistics
    always_comb begin
        pl           = bus.s_axis_tdata[19:0];
        unused_tdata = ^bus.s_axis_tdata[31:20];
        acc          = bus.s_axis_tvalid && tready_q;
        tlast_acc    = acc && bus.s_axis_tlast;
        last_col     = col_q == CW'(H_ACTIVE - 1);
        last_row     = row_q == RW'(V_ACTIVE - 1);
        stats        = last_row && col_q >= CW'(H_ACTIVE - 2);
        chg          = acc && !stats && pl != prev_q;
        push         = state_q == HAVE_P1 && chg && pl != '0;
        orphan_inc   = state_q == HAVE_P1 && !push && (chg || tlast_acc);
        pop          = level_q != '0 && bus.m_match_ready;
        full         = level_q == LW'(DEPTH);
        wr_en        = push && (!full || pop);
`ifdef FRAME_TAG_EN
        rec          = {frame_cnt_q[7:0], pl[9:0], pl[19:10], p1_q[9:0], p1_q[19:10]};
`else
        rec          = {pl[9:0], pl[19:10], p1_q[9:0], p1_q[19:10]};
`endif
        state_d = state_q;
        p1_d    = p1_q;
        if (state_q == SYNC) begin
            state_d = tlast_acc ? IDLE : SYNC;
        end else if (state_q == IDLE && chg && pl != '0) begin
            state_d = HAVE_P1;
            p1_d    = pl;
        end else if (state_q == HAVE_P1 && (chg || tlast_acc)) begin
            state_d = IDLE;
        end
        col_d          = !acc ? col_q : (bus.s_axis_tlast || last_col) ? '0 : col_q + CW'(1);
        row_d          = (!acc || (!bus.s_axis_tlast && !last_col)) ? row_q :
                         (bus.s_axis_tlast || last_row) ? '0 : row_q + RW'(1);
        prev_d         = chg ? pl : prev_q;
        tready_d       = 1'b1;
        frame_done_d   = tlast_acc;
        frame_err_d    = frame_err_q || (tlast_acc && state_q != SYNC && !(last_row && last_col));
        frame_cycles_d = (acc && stats && last_col) ? pl : frame_cycles_q;
        frame_cnt_d    = frame_cnt_q + 16'(tlast_acc);
        orphan_d       = (orphan_inc && orphan_q != 16'hFFFF) ? orphan_q + 16'd1 : orphan_q;
        overflow_d     = (push && full && !pop && overflow_q != 16'hFFFF) ? overflow_q + 16'd1 : overflow_q;
        wr_d           = wr_q + AW'(wr_en);
        rd_d           = rd_q + AW'(pop);
        level_d        = level_q + LW'(wr_en) - LW'(pop);
    end
    // State register with synchronous reset
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            state_q        <= SYNC;
            col_q          <= '0;
            row_q          <= '0;
            prev_q         <= '0;
            p1_q           <= '0;
            tready_q       <= 1'b0;
            frame_done_q   <= 1'b0;
            frame_err_q    <= 1'b0;
            frame_cycles_q <= '0;
            frame_cnt_q    <= '0;
            orphan_q       <= '0;
            overflow_q     <= '0;
            wr_q           <= '0;
            rd_q           <= '0;
            level_q        <= '0;
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            row_q          <= row_d;
            prev_q         <= prev_d;
            p1_q           <= p1_d;
            tready_q       <= tready_d;
            frame_done_q   <= frame_done_d;
            frame_err_q    <= frame_err_d;
            frame_cycles_q <= frame_cycles_d;
            frame_cnt_q    <= frame_cnt_d;
            orphan_q       <= orphan_d;
            overflow_q     <= overflow_d;
            wr_q           <= wr_d;
            rd_q           <= rd_d;
            level_q        <= level_d;
        end
    end
    // Record storage; contents are don't-care until the level says otherwise
    always_ff @(posedge s_axis_aclk) begin
        if (wr_en) mem_q[wr_q] <= rec;
    end
    assign bus.s_axis_tready = tready_q;
    assign bus.m_match_valid = level_q != '0;
    assign bus.m_match_data  = level_q != '0 ? mem_q[rd_q] : '0;
    assign match_level       = level_q;
    assign frame_cycles      = frame_cycles_q;
    assign frame_cnt         = frame_cnt_q;
    assign frame_done        = frame_done_q;
    assign frame_err         = frame_err_q;
    assign orphan_cnt        = orphan_q;
    assign overflow_cnt      = overflow_q;
endmodule
